// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg
//   Shared definitions for the two-requester PSRAM channel-0 arbiter:
//   FSM state encoding, data-mask constants and address widths.
//   Optional feature macro used by the arbiter files: PSRAM_ARB_RR_EN
//   (round-robin winner selection instead of fixed CPU priority).
package psram_arb_pkg;

  // Requester-side byte address and PSRAM-side 16-bit word address widths.
  localparam int RQ_ADDR_W = 22;
  localparam int PS_ADDR_W = 21;

  // Mask bits set to 1 suppress the corresponding byte lane of wr_data.
  localparam logic [3:0] MASK_WORD = 4'b0011;
  localparam logic [3:0] MASK_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } arb_state_t;

  // Byte write: the data sits in the upper half of wr_data, so the upper
  // lane pair is selected by address bit 0 and the lower pair stays masked.
  function automatic logic [3:0] byte_mask(input logic a0);
    return {~a0, a0, 2'b11};
  endfunction

endpackage

// File: rtl/psram_arb_pick.sv
// psram_arb_pick
//   Winner selection between requester 0 (CPU) and requester 1 (DMA).
//   Build option: PSRAM_ARB_RR_EN
//     defined   -> round-robin; on a tie the requester other than rr_last
//                  wins, rr_last is updated on every grant (reset value 1).
//     undefined -> fixed priority, CPU wins ties; no state, no clock.
// Ports:
//   clk_out, rst_n, grant  (round-robin build only) clock, async reset,
//                          grant strobe that updates rr_last
//   req[1:0]               per-requester pending level
//   win                    index of the winning requester
//   any                    at least one request pending
module psram_arb_pick
  import psram_arb_pkg::*;
(
`ifdef PSRAM_ARB_RR_EN
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic       grant,
`endif
  input  logic [1:0] req,
  output logic       win,
  output logic       any
);

`ifdef PSRAM_ARB_RR_EN
  logic rr_last;

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (grant) begin
      rr_last <= win;
    end
  end
`endif

  always_comb begin
    any = |req;
    win = 1'b0;
`ifdef PSRAM_ARB_RR_EN
    if (req[0] && req[1]) begin
      win = ~rr_last;
    end else begin
      win = req[1];
    end
`else
    win = ~req[0] & req[1];
`endif
  end

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Arbitrates CPU (requester 0) and DMA (requester 1) level requests onto
//   PSRAM channel 0. One transaction at a time: IDLE -> CMD -> WAIT -> DONE.
//   Build option: PSRAM_ARB_RR_EN selects round-robin arbitration in
//   psram_arb_pick; without it the CPU always wins ties.
// Ports:
//   clk_out, rst_n            clock (posedge), async active-low reset
//   init_calib                PSRAM calibration done; no grant while low
//   rq_read, rq_write [1:0]   level requests (read wins if both set)
//   rq_byte [1:0]             byte-write qualifier
//   rq_addr0/1 [21:0]         byte addresses
//   rq_wdata0/1 [15:0]        write data
//   rq_rdata [15:0]           shared read data, valid with rq_done
//   rq_done [1:0]             one-cycle completion pulse
//   cmd, cmd_en               channel-0 command (1=write) and strobe
//   addr [20:0], wr_data [31:0], data_mask [3:0]  channel-0 command fields
//   rd_data [31:0], rd_data_valid                 channel-0 read return
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int RD_CYCLES = 14,
  parameter int WR_CYCLES = 14
) (
  input  logic                 clk_out,
  input  logic                 rst_n,
  input  logic                 init_calib,
  input  logic [1:0]           rq_read,
  input  logic [1:0]           rq_write,
  input  logic [1:0]           rq_byte,
  input  logic [RQ_ADDR_W-1:0] rq_addr0,
  input  logic [RQ_ADDR_W-1:0] rq_addr1,
  input  logic [15:0]          rq_wdata0,
  input  logic [15:0]          rq_wdata1,
  output logic [15:0]          rq_rdata,
  output logic [1:0]           rq_done,
  output logic                 cmd,
  output logic                 cmd_en,
  output logic [PS_ADDR_W-1:0] addr,
  output logic [31:0]          wr_data,
  output logic [3:0]           data_mask,
  input  logic [31:0]          rd_data,
  input  logic                 rd_data_valid
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);

  arb_state_t           state;
  arb_state_t           state_nxt;
  logic [1:0]           req_lvl;
  logic                 win;
  logic                 any_req;
  logic                 grant;
  logic                 win_q;
  logic                 op_wr_q;
  logic                 beat_seen;
  logic [CNT_W-1:0]     cnt;
  logic                 cnt_done;
  logic                 sel_rd;
  logic                 sel_byte;
  logic [RQ_ADDR_W-1:0] sel_addr;
  logic [15:0]          sel_wdata;
  logic                 rd_data_unused;

  // Only the upper half of a read beat carries the 16-bit word.
  assign rd_data_unused = ^rd_data[15:0];

  assign req_lvl = rq_read | rq_write;
  assign grant   = (state == ST_IDLE) && init_calib && any_req;

  psram_arb_pick u_pick (
`ifdef PSRAM_ARB_RR_EN
    .clk_out (clk_out),
    .rst_n   (rst_n),
    .grant   (grant),
`endif
    .req     (req_lvl),
    .win     (win),
    .any     (any_req)
  );

  // Fields of the winning requester; a read request overrides a write.
  assign sel_rd    = rq_read[win];
  assign sel_byte  = rq_byte[win];
  assign sel_addr  = win ? rq_addr1 : rq_addr0;
  assign sel_wdata = win ? rq_wdata1 : rq_wdata0;

  assign cnt_done = op_wr_q ? (cnt == WR_LAST) : (cnt == RD_LAST);

  // ---- FSM state register ----
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant)            state_nxt = ST_CMD;
      ST_CMD:                        state_nxt = ST_WAIT;
      ST_WAIT: if (cnt_done)         state_nxt = ST_DONE;
      // Holding here until the winner lets go keeps a stale level from
      // being granted a second time.
      ST_DONE: if (!req_lvl[win_q])  state_nxt = ST_IDLE;
      default:                       state_nxt = ST_IDLE;
    endcase
  end

  // ---- Grant latch and channel command ----
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= 1'b0;
      op_wr_q   <= 1'b0;
      cmd_en    <= 1'b0;
      cmd       <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      data_mask <= MASK_NONE;
    end else begin
      cmd_en    <= grant;
      data_mask <= MASK_NONE;
      if (grant) begin
        win_q   <= win;
        op_wr_q <= ~sel_rd;
        cmd     <= ~sel_rd;
        addr    <= sel_addr[RQ_ADDR_W-1:1];
        if (!sel_rd) begin
          wr_data   <= {sel_wdata, 16'h0000};
          data_mask <= sel_byte ? byte_mask(sel_addr[0]) : MASK_WORD;
        end
      end
    end
  end

  // ---- Wait counter, read capture and completion ----
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      beat_seen <= 1'b0;
      rq_rdata  <= '0;
      rq_done   <= 2'b00;
    end else begin
      rq_done <= 2'b00;
      if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (grant) begin
        beat_seen <= 1'b0;
      end
      // Only the first beat of a read's wait window is taken; beats at any
      // other time, or during a write, are dropped.
      if ((state == ST_WAIT) && !op_wr_q && rd_data_valid && !beat_seen) begin
        rq_rdata  <= rd_data[31:16];
        beat_seen <= 1'b1;
      end
      if ((state == ST_WAIT) && cnt_done) begin
        rq_done <= win_q ? 2'b10 : 2'b01;
      end
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
module tb_psram_arbiter;
  localparam int RD_C = 6;
  localparam int WR_C = 4;

  logic        clk_out = 1'b0;
  logic        rst_n;
  logic        init_calib;
  logic [1:0]  rq_read, rq_write, rq_byte;
  logic [21:0] rq_addr0, rq_addr1;
  logic [15:0] rq_wdata0, rq_wdata1;
  logic [15:0] rq_rdata;
  logic [1:0]  rq_done;
  logic        cmd, cmd_en;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  data_mask;
  logic [31:0] rd_data;
  logic        rd_data_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk_out = ~clk_out;

  psram_arbiter #(.RD_CYCLES(RD_C), .WR_CYCLES(WR_C)) dut (
    .clk_out       (clk_out),
    .rst_n         (rst_n),
    .init_calib    (init_calib),
    .rq_read       (rq_read),
    .rq_write      (rq_write),
    .rq_byte       (rq_byte),
    .rq_addr0      (rq_addr0),
    .rq_addr1      (rq_addr1),
    .rq_wdata0     (rq_wdata0),
    .rq_wdata1     (rq_wdata1),
    .rq_rdata      (rq_rdata),
    .rq_done       (rq_done),
    .cmd           (cmd),
    .cmd_en        (cmd_en),
    .addr          (addr),
    .wr_data       (wr_data),
    .data_mask     (data_mask),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid)
  );

  task automatic test_reset();
    rst_n = 1'b0; init_calib = 1'b1;
    rq_read = 2'b00; rq_write = 2'b00; rq_byte = 2'b00;
    rq_addr0 = '0; rq_addr1 = '0; rq_wdata0 = '0; rq_wdata1 = '0;
    rd_data = '0; rd_data_valid = 1'b0;
    repeat (2) @(negedge clk_out);
    total++; if (cmd_en !== 1'b0) begin bad++; $display("FAIL rst_cmd_en got %0b want 0", cmd_en); end
    total++; if (cmd !== 1'b0) begin bad++; $display("FAIL rst_cmd got %0b want 0", cmd); end
    total++; if (addr !== 21'h0) begin bad++; $display("FAIL rst_addr got %h want 0", addr); end
    total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
    total++; if (data_mask !== 4'b1111) begin bad++; $display("FAIL rst_mask got %b want 1111", data_mask); end
    total++; if (rq_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", rq_rdata); end
    total++; if (rq_done !== 2'b00) begin bad++; $display("FAIL rst_done got %b want 00", rq_done); end
    rst_n = 1'b1;
    @(negedge clk_out);
  endtask

  task automatic test_word_write();
    int pulses, dones, done_k;
    pulses = 0; dones = 0; done_k = -1;
    rq_addr0 = 22'h000100; rq_wdata0 = 16'hABCD; rq_byte = 2'b00; rq_write = 2'b01;
    for (int i = 1; i <= WR_C + 5; i++) begin
      @(negedge clk_out);
      if (cmd_en === 1'b1) pulses++;
      if (rq_done[0] === 1'b1) begin dones++; if (done_k < 0) done_k = i; end
      if (i == 1) begin
        total++; if (cmd_en !== 1'b1) begin bad++; $display("FAIL ww_cmd_en got %0b want 1", cmd_en); end
        total++; if (cmd !== 1'b1) begin bad++; $display("FAIL ww_cmd got %0b want 1", cmd); end
        total++; if (addr !== 21'h000080) begin bad++; $display("FAIL ww_addr got %h want 000080", addr); end
        total++; if (wr_data !== 32'hABCD0000) begin bad++; $display("FAIL ww_wr_data got %h want abcd0000", wr_data); end
        total++; if (data_mask !== 4'b0011) begin bad++; $display("FAIL ww_mask got %b want 0011", data_mask); end
      end
      if (i == 2) begin
        total++; if (data_mask !== 4'b1111) begin bad++; $display("FAIL ww_mask_after got %b want 1111", data_mask); end
      end
      // stray beat during a write's wait window must be dropped
      rd_data_valid = (i == 2); rd_data = 32'hDEAD0000;
    end
    rd_data_valid = 1'b0;
    total++; if (pulses != 1) begin bad++; $display("FAIL ww_cmd_pulses got %0d want 1", pulses); end
    total++; if (dones != 1) begin bad++; $display("FAIL ww_done_pulses got %0d want 1", dones); end
    total++; if (done_k != WR_C + 2) begin bad++; $display("FAIL ww_done_cycle got %0d want %0d", done_k, WR_C + 2); end
    total++; if (rq_rdata !== 16'h0000) begin bad++; $display("FAIL ww_rdata_kept got %h want 0000", rq_rdata); end
    rq_write = 2'b00;
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_byte_write();
    logic [21:0] a_tab [2];
    logic [3:0]  m_tab [2];
    int done_k;
    a_tab[0] = 22'h000101; m_tab[0] = 4'b0111;
    a_tab[1] = 22'h000100; m_tab[1] = 4'b1011;
    for (int v = 0; v < 2; v++) begin
      done_k = -1;
      rq_addr1 = a_tab[v]; rq_wdata1 = 16'h00A5; rq_byte = 2'b10; rq_write = 2'b10;
      for (int i = 1; i <= WR_C + 4; i++) begin
        @(negedge clk_out);
        if (rq_done[1] === 1'b1 && done_k < 0) done_k = i;
        if (i == 1) begin
          total++; if (data_mask !== m_tab[v]) begin bad++; $display("FAIL bw_mask%0d got %b want %b", v, data_mask, m_tab[v]); end
          total++; if (addr !== 21'h000080) begin bad++; $display("FAIL bw_addr%0d got %h want 000080", v, addr); end
        end
      end
      total++; if (done_k != WR_C + 2) begin bad++; $display("FAIL bw_done%0d got %0d want %0d", v, done_k, WR_C + 2); end
      rq_write = 2'b00; rq_byte = 2'b00;
      repeat (2) @(negedge clk_out);
    end
  endtask

  task automatic test_read();
    int done_k;
    done_k = -1;
    rq_addr0 = 22'h000200; rq_read = 2'b01;
    for (int i = 1; i <= RD_C + 4; i++) begin
      @(negedge clk_out);
      if (rq_done[0] === 1'b1 && done_k < 0) begin
        done_k = i;
        total++; if (rq_rdata !== 16'h1234) begin bad++; $display("FAIL rd_rdata got %h want 1234", rq_rdata); end
      end
      if (i == 1) begin
        total++; if (cmd !== 1'b0) begin bad++; $display("FAIL rd_cmd got %0b want 0", cmd); end
        total++; if (addr !== 21'h000100) begin bad++; $display("FAIL rd_addr got %h want 000100", addr); end
      end
      rd_data_valid = (i == 2) || (i == 3);
      rd_data = (i == 2) ? 32'h12345678 : 32'h9ABCDEF0;
    end
    rd_data_valid = 1'b0;
    total++; if (done_k != RD_C + 2) begin bad++; $display("FAIL rd_done got %0d want %0d", done_k, RD_C + 2); end
    rq_read = 2'b00;
    @(negedge clk_out);
    // beat while idle must be ignored
    rd_data_valid = 1'b1; rd_data = 32'h55550000;
    @(negedge clk_out);
    rd_data_valid = 1'b0;
    @(negedge clk_out);
    total++; if (rq_rdata !== 16'h1234) begin bad++; $display("FAIL rd_idle_beat got %h want 1234", rq_rdata); end
  endtask

  task automatic test_read_no_beat();
    int done_k;
    done_k = -1;
    rq_addr0 = 22'h000300; rq_read = 2'b01; rq_write = 2'b01;
    for (int i = 1; i <= RD_C + 4; i++) begin
      @(negedge clk_out);
      if (rq_done[0] === 1'b1 && done_k < 0) done_k = i;
      if (i == 1) begin
        total++; if (cmd !== 1'b0) begin bad++; $display("FAIL rw_cmd got %0b want 0", cmd); end
      end
    end
    total++; if (done_k != RD_C + 2) begin bad++; $display("FAIL rw_done got %0d want %0d", done_k, RD_C + 2); end
    total++; if (rq_rdata !== 16'h1234) begin bad++; $display("FAIL rw_rdata got %h want 1234", rq_rdata); end
    rq_read = 2'b00; rq_write = 2'b00;
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_back_to_back();
    int first_k, second_k, k;
    first_k = -1; second_k = -1; k = 0;
    rq_addr0 = 22'h000010; rq_addr1 = 22'h000020; rq_write = 2'b01;
    while (k < 30 && second_k < 0) begin
      @(negedge clk_out);
      k++;
      if (cmd_en === 1'b1) begin if (first_k < 0) first_k = k; else second_k = k; end
      if (k == 2) rq_write[1] = 1'b1;
      if (rq_done[0] === 1'b1) rq_write[0] = 1'b0;
    end
    total++; if (first_k != 1) begin bad++; $display("FAIL b2b_first got %0d want 1", first_k); end
    total++; if (second_k - first_k != WR_C + 3) begin bad++; $display("FAIL b2b_spacing got %0d want %0d", second_k - first_k, WR_C + 3); end
    k = 0;
    while (k < 30 && rq_done[1] !== 1'b1) begin @(negedge clk_out); k++; end
    total++; if (rq_done[1] !== 1'b1) begin bad++; $display("FAIL b2b_dma_done got %b want 1", rq_done[1]); end
    rq_write = 2'b00;
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_init_calib();
    int pulses, k;
    pulses = 0;
    init_calib = 1'b0; rq_addr1 = 22'h000040; rq_write = 2'b10;
    repeat (6) begin @(negedge clk_out); if (cmd_en === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL cal_blocked got %0d want 0", pulses); end
    init_calib = 1'b1;
    k = 0;
    while (k < 2 && cmd_en !== 1'b1) begin @(negedge clk_out); k++; end
    total++; if (cmd_en !== 1'b1) begin bad++; $display("FAIL cal_grant got %0b want 1", cmd_en); end
    @(negedge clk_out);
    init_calib = 1'b0;
    k = 0;
    while (k < 20 && rq_done[1] !== 1'b1) begin @(negedge clk_out); k++; end
    total++; if (rq_done[1] !== 1'b1) begin bad++; $display("FAIL cal_complete got %b want 1", rq_done[1]); end
    rq_write = 2'b00;
    @(negedge clk_out);
    rq_write = 2'b10; pulses = 0;
    repeat (6) begin @(negedge clk_out); if (cmd_en === 1'b1) pulses++; end
    total++; if (pulses != 0) begin bad++; $display("FAIL cal_regrant got %0d want 0", pulses); end
    init_calib = 1'b1;
    k = 0;
    while (k < 20 && rq_done[1] !== 1'b1) begin @(negedge clk_out); k++; end
    rq_write = 2'b00;
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_reset_mid();
    int dones, done_k;
    dones = 0; done_k = -1;
    rq_addr0 = 22'h000100; rq_wdata0 = 16'h1111; rq_write = 2'b01;
    repeat (3) @(negedge clk_out);
    rst_n = 1'b0;
    #1;
    total++; if (cmd_en !== 1'b0 || cmd !== 1'b0 || addr !== 21'h0) begin bad++; $display("FAIL rm_cmd got en=%0b cmd=%0b addr=%h want 0 0 0", cmd_en, cmd, addr); end
    total++; if (wr_data !== 32'h0 || data_mask !== 4'b1111) begin bad++; $display("FAIL rm_data got %h %b want 0 1111", wr_data, data_mask); end
    total++; if (rq_rdata !== 16'h0) begin bad++; $display("FAIL rm_rdata got %h want 0", rq_rdata); end
    rq_write = 2'b00;
    repeat (2) @(negedge clk_out);
    rst_n = 1'b1;
    repeat (WR_C + 4) begin @(negedge clk_out); if (rq_done !== 2'b00) dones++; end
    total++; if (dones != 0) begin bad++; $display("FAIL rm_no_done got %0d want 0", dones); end
    rq_addr1 = 22'h000050; rq_write = 2'b10;
    for (int i = 1; i <= WR_C + 4; i++) begin
      @(negedge clk_out);
      if (rq_done[1] === 1'b1 && done_k < 0) done_k = i;
    end
    total++; if (done_k != WR_C + 2) begin bad++; $display("FAIL rm_next got %0d want %0d", done_k, WR_C + 2); end
    rq_write = 2'b00;
    repeat (2) @(negedge clk_out);
  endtask

  task automatic test_arbitration();
    logic exp_w [4];
    logic w;
    int cyc;
`ifdef PSRAM_ARB_RR_EN
    exp_w[0] = 1'b0; exp_w[1] = 1'b1; exp_w[2] = 1'b0; exp_w[3] = 1'b1;
`else
    exp_w[0] = 1'b0; exp_w[1] = 1'b0; exp_w[2] = 1'b0; exp_w[3] = 1'b0;
`endif
    rq_addr0 = 22'h000400; rq_addr1 = 22'h000500; rq_read = 2'b11;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      while (rq_done === 2'b00 && cyc < 40) begin @(negedge clk_out); cyc++; end
      total++;
      if (cyc >= 40) begin
        bad++; $display("FAIL arb_timeout%0d got none want done", n);
      end else begin
        w = rq_done[1];
        if (w !== exp_w[n]) begin bad++; $display("FAIL arb_winner%0d got %0b want %0b", n, w, exp_w[n]); end
        rq_read[w] = 1'b0;
        @(negedge clk_out);
        rq_read[w] = 1'b1;
      end
    end
    rq_read = 2'b00;
    repeat (20) @(negedge clk_out);
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_write();
    test_read();
    test_read_no_beat();
    test_back_to_back();
    test_init_calib();
    test_reset_mid();
    test_arbitration();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 SHALL have parameter RD_CYCLES, default 14, giving the clk_out cycles from read cmd_en until the channel is free.
REQ-002 SHALL have parameter WR_CYCLES, default 14, giving the clk_out cycles from write cmd_en until the channel is free.
REQ-003 clk_out  in  1  clock; all logic on posedge clk_out.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 init_calib  in  1  PSRAM calibration done; no grant while low.
REQ-006 rq_read[1:0], rq_write[1:0]  in  2 each  per-requester level requests (0=CPU, 1=DMA).
REQ-007 rq_byte[1:0]  in  2  byte-write qualifier per requester.
REQ-008 rq_addr0, rq_addr1  in  22 each  byte addresses.
REQ-009 rq_wdata0, rq_wdata1  in  16 each  write data.
REQ-010 rq_rdata  out  16  read data, shared and valid when rq_done is set.
REQ-011 rq_done[1:0]  out  2  one-cycle completion pulse per requester.
REQ-012 cmd, cmd_en  out  1 each  PSRAM channel-0 command (1=write) and strobe.
REQ-013 addr  out  21 ; wr_data  out  32 ; data_mask  out  4  channel-0 command fields.
REQ-014 rd_data  in  32 ; rd_data_valid  in  1  channel-0 read return.

Function
REQ-015 SHALL run the FSM IDLE -> CMD -> WAIT -> DONE -> IDLE.
REQ-016 IDLE: with init_calib=1 and any request pending, SHALL pick a winner, latch its op/addr/data, and go to CMD on the next edge.
REQ-017 A requester asserting rq_read and rq_write together SHALL be treated as a read.
REQ-018 CMD: cmd_en=1 for exactly one cycle; addr=latched addr[21:1]; cmd=1 for write.
REQ-019 Word write: wr_data={wdata,16'h0}, data_mask=4'b0011.
REQ-020 Byte write: data_mask={!addr[0],addr[0],2'b11}.
REQ-021 data_mask SHALL be 4'b1111 outside CMD.
REQ-022 WAIT: a counter SHALL run to RD_CYCLES or WR_CYCLES.
REQ-023 During a read's WAIT, the first rd_data_valid beat SHALL load rq_rdata<=rd_data[31:16]; later beats are ignored.
REQ-024 If no rd_data_valid arrives before the counter expires, rq_rdata SHALL hold its old value and the arbiter SHALL still complete.
REQ-025 DONE: rq_done[winner]=1 for one cycle.
REQ-026 The FSM SHALL then stay in DONE until the winner's request drops, then go to IDLE; this blocks a re-grant of a stale level.
REQ-027 Minimum spacing between cmd_en pulses SHALL be RD/WR_CYCLES+3.
REQ-028 rd_data_valid outside a read WAIT SHALL be ignored.
REQ-029 If init_calib falls mid-transaction, the FSM SHALL complete the transaction, then not grant again until init_calib rises.

Reset
REQ-030 On rst_n low, the FSM SHALL enter IDLE and the counter SHALL clear.
REQ-031 Output reset values: cmd_en=0, cmd=0, addr=0, wr_data=0, data_mask=4'b1111, rq_rdata=0, rq_done=0, rr_last=1.
REQ-032 Reset mid-transaction SHALL abandon the transaction without issuing rq_done.

Configuration
REQ-033 With PSRAM_ARB_RR_EN defined, the arbiter SHALL grant round-robin: the winner is the requester other than rr_last when both request; rr_last updates at grant.
REQ-034 Without PSRAM_ARB_RR_EN, requester 0 (CPU) SHALL always win ties, and rr_last SHALL be absent.

Structure
REQ-035 Package psram_arb_pkg SHALL hold the FSM state enum, the mask constants MASK_WORD=4'b0011 and MASK_NONE=4'b1111, and the address width constants 22/21.
REQ-036 The winner selection SHALL be one sub-module, psram_arb_pick (combinational plus the rr_last flop).
REQ-037 The rest SHALL be flat in psram_arbiter.

Verification
REQ-038 CPU word write, addr=22'h000100, wdata=16'hABCD -> one cmd_en, cmd=1, addr=21'h80, wr_data=32'hABCD0000, mask=4'b0011, rq_done[0] at cycle WR_CYCLES+2.
REQ-039 DMA byte write to addr=22'h000101 -> mask=4'b0111; to addr=22'h000100 -> mask=4'b1011.
REQ-040 CPU read with rd_data_valid beats 32'h12345678 then 32'h9ABCDEF0 -> rq_rdata=16'h1234 at rq_done[0].
REQ-041 Both requesters read continuously, RR_EN defined -> grants alternate 0,1,0,1; RR_EN undefined -> only 0 is granted while its request keeps cycling.
REQ-042 Request held with init_calib=0 -> no cmd_en; init_calib rises -> cmd_en within 2 cycles.
REQ-043 rst_n pulsed low during WAIT -> no rq_done; outputs at reset values; the next request is served normally.
